spi_reg_sequencer: RTL and testbench
====================================

# spi_reg_sequencer

Transaction sequencer between the SPI byte engine (spi_slave) and the register wrapper. Decodes the command byte {rw, addr[6:0]}, then runs a burst of single-cycle register accesses: each write byte becomes one write strobe, and each read byte becomes one fetch. The address auto-increments except at streaming addresses (packet/FIFO ports), where it stays fixed. It also flags unmapped accesses and read overruns in sticky error bits.

## Interface
- ADDR_MAX, 7'h09, highest mapped register address; higher addresses are unmapped.
- STREAM_MAP, 16'h0128, bit i set means address i is a streaming port with no auto-increment (defaults: 0x03 tx_packet, 0x05 rx_packet, 0x08 fifo).
- clk  in  1  system clock; the block has one clock.
- reset_n  in  1  asynchronous, active-low reset.
- cs_n  in  1  SPI chip select, already synchronized to clk; high means no transaction.
- rx_byte  in  8  byte received from spi_slave.
- rx_byte_dv  in  1  one-cycle strobe, rx_byte valid.
- tx_byte_req  in  1  one-cycle strobe, spi_slave needs the next read byte.
- tx_byte  out  8  byte for spi_slave to shift out.
- tx_byte_load  out  1  one-cycle strobe, tx_byte valid.
- reg_addr  out  7  register address.
- addr_dv  out  1  one-cycle access strobe.
- rw_out  out  1  1 = read, 0 = write; valid when addr_dv is high.
- rxdv  out  1  write-data strobe, coincident with addr_dv on writes.
- rx_d  out  8  write data.
- tx_d  in  8  read data from the wrapper, valid in the addr_dv cycle.
- tx_en  in  1  wrapper read-hit indication, valid in the addr_dv cycle.
- busy  out  1  high in any state other than IDLE.
- byte_cnt  out  8  data bytes in the current burst, saturating at 255; cleared on command.
- err_unmapped  out  1  sticky flag: access attempted above ADDR_MAX.
- err_overrun  out  1  sticky flag: tx_byte_req arrived while a fetch was pending.
- err_clr  in  1  clears both sticky errors; a set in the same cycle wins.

## Operation
- States: IDLE, CMD, WR, RD, RD_FETCH, RD_LOAD.
- IDLE: entered when cs_n is sampled low; next state CMD.
- CMD: on rx_byte_dv, latch reg_addr = rx_byte[6:0] and the rw bit = rx_byte[7], and clear byte_cnt.
  - rw = 0: go to WR.
  - rw = 1: go to RD; a tx_byte_req in the same cycle is honored.
- WR: on rx_byte_dv, in the next cycle drive addr_dv = rxdv = 1, rw_out = 0, rx_d = byte.
  - The address update for the next byte happens in the same cycle.
  - Back-to-back bytes are accepted every cycle.
- RD: on tx_byte_req, go to RD_FETCH.
- RD_FETCH: drive addr_dv = 1 and rw_out = 1 for exactly one cycle, and sample tx_d/tx_en; then go to RD_LOAD.
- RD_LOAD: drive tx_byte and pulse tx_byte_load; advance the address; return to RD.
- Read data rule: tx_byte = tx_d if tx_en = 1, otherwise 0x00.
- Address update after each access:
  - Unchanged if STREAM_MAP[addr] = 1 and addr < 16.
  - Otherwise addr + 1, mod 128 (0x7F wraps to 0x00).
- Unmapped access (addr > ADDR_MAX):
  - addr_dv, rxdv and the fetch are suppressed.
  - err_unmapped is set.
  - A read still loads tx_byte = 0x00 on schedule.
  - The address still advances.
- byte_cnt increments once per processed data byte (write byte or read load).
- Overrun: a tx_byte_req seen in RD_FETCH or RD_LOAD is ignored and sets err_overrun.
- rx_byte_dv in the read states is ignored (dummy bytes).
- cs_n high in any state:
  - Next state is IDLE.
  - A write whose rx_byte_dv was in that same cycle is still issued.
  - A pending read load is dropped.
  - An addr_dv already on the bus completes; no new addr_dv is issued.

## Timing
- Write latency: rx_byte_dv at cycle N gives addr_dv/rxdv/rx_d at N+1.
- Read latency: tx_byte_req at cycle M gives addr_dv (read) at M+1 and tx_byte_load at M+2.
  - spi_slave must allow at least 2 clk cycles between req and the first shift.
- addr_dv is never high for more than one cycle per access, so streaming ports pop or push exactly once per byte.
- Reset values:
  - State IDLE; reg_addr 0; addr_dv, rxdv, rw_out, tx_byte_load, busy all 0.
  - rx_d 0x00; tx_byte 0x00; byte_cnt 0; both error flags 0.
- Reset is asynchronous mid-transaction and forces all of these reset values immediately.

## Test plan
- Write burst, cmd 0x06 then 0xAA, 0x55 one per cycle:
  - Strobes at addr 0x06 (data 0xAA) and 0x07 (data 0x55), each one cycle after its dv.
  - byte_cnt = 2.
- FIFO read burst, cmd 0x88 then 3 tx_byte_req:
  - Three addr_dv pulses, all at addr 0x08 with rw_out = 1.
  - tx_byte equals tx_d each time, with the load 2 cycles after each req.
- Unmapped and wrap, cmd 0x7F write then 2 bytes:
  - No addr_dv; err_unmapped = 1; addresses 0x7F then 0x00.
  - The second byte is at 0x00, which is mapped, so it is strobed.
- Overrun: cmd 0x81, then req at M and M+1:
  - One fetch only; err_overrun = 1.
  - err_clr pulse returns err_overrun to 0.
- Abort: cs_n high during RD_FETCH:
  - The fetch completes, no tx_byte_load is issued, IDLE next cycle, busy = 0.
- Async reset asserted mid write burst: all outputs at reset values in the same cycle; no further strobes.

Source files
------------

// File: rtl/spi_reg_sequencer.sv
// SPI command/burst sequencer between spi_slave and the register wrapper.
// Ports: cs_n/rx_byte/tx_byte_* from spi_slave; reg_addr/addr_dv/rw_out/rxdv/rx_d/tx_d/tx_en to the wrapper; busy/byte_cnt/err_* status.
module spi_reg_sequencer #(
  parameter logic [6:0]  ADDR_MAX   = 7'h09,
  parameter logic [15:0] STREAM_MAP = 16'h0128
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_dv,
  input  logic       tx_byte_req,
  output logic [7:0] tx_byte,
  output logic       tx_byte_load,
  output logic [6:0] reg_addr,
  output logic       addr_dv,
  output logic       rw_out,
  output logic       rxdv,
  output logic [7:0] rx_d,
  input  logic [7:0] tx_d,
  input  logic       tx_en,
  output logic       busy,
  output logic [7:0] byte_cnt,
  output logic       err_unmapped,
  output logic       err_overrun,
  input  logic       err_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WR,
    S_RD,
    S_RD_FETCH,
    S_RD_LOAD
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic       wr_pend_q, wr_pend_d;
  logic [7:0] rx_d_q, rx_d_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       err_unm_q, err_unm_d;
  logic       err_ovr_q, err_ovr_d;

  logic       mapped;
  logic       stream;
  logic [6:0] addr_nxt;
  logic       rd_fetch;
  logic       rd_load;
  logic       set_unm;
  logic       set_ovr;
  logic       cnt_inc;
  logic       cnt_clr;

  assign mapped   = reg_addr_q <= ADDR_MAX;
  assign stream   = (reg_addr_q[6:4] == 3'b000)
                  && STREAM_MAP[reg_addr_q[3:0]];
  assign addr_nxt = stream ? reg_addr_q
                           : reg_addr_q + 7'd1;
  assign rd_fetch = state_q == S_RD_FETCH;
  // A load still pending when cs_n rises is dropped.
  assign rd_load  = (state_q == S_RD_LOAD) && !cs_n;

  // The write strobe lives one cycle after its byte, so a write whose byte
  // arrived together with cs_n rising still completes from IDLE.
  assign addr_dv      = mapped && (wr_pend_q || rd_fetch);
  assign rxdv         = mapped && wr_pend_q;
  assign rw_out       = rd_fetch;
  assign tx_byte_load = rd_load;
  assign reg_addr     = reg_addr_q;
  assign rx_d         = rx_d_q;
  assign tx_byte      = tx_byte_q;
  assign byte_cnt     = byte_cnt_q;
  assign busy         = state_q != S_IDLE;
  assign err_unmapped = err_unm_q;
  assign err_overrun  = err_ovr_q;

  always_comb begin
    state_d    = state_q;
    reg_addr_d = reg_addr_q;
    wr_pend_d  = 1'b0;
    rx_d_d     = rx_d_q;
    tx_byte_d  = tx_byte_q;
    set_unm    = 1'b0;
    set_ovr    = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;

    // Address advances in the strobe cycle, even for unmapped accesses.
    if (wr_pend_q) begin
      reg_addr_d = addr_nxt;
      cnt_inc    = 1'b1;
      set_unm    = !mapped;
    end
    if (rd_load) begin
      reg_addr_d = addr_nxt;
      cnt_inc    = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!cs_n) state_d = S_CMD;
      end
      S_CMD: begin
        if (cs_n) begin
          state_d = S_IDLE;
        end else if (rx_byte_dv) begin
          reg_addr_d = rx_byte[6:0];
          cnt_clr    = 1'b1;
          if (rx_byte[7])
            state_d = tx_byte_req ? S_RD_FETCH : S_RD;
          else
            state_d = S_WR;
        end
      end
      S_WR: begin
        if (rx_byte_dv) begin
          wr_pend_d = 1'b1;
          rx_d_d    = rx_byte;
        end
        if (cs_n) state_d = S_IDLE;
      end
      S_RD: begin
        if (cs_n)             state_d = S_IDLE;
        else if (tx_byte_req) state_d = S_RD_FETCH;
      end
      S_RD_FETCH: begin
        set_ovr = tx_byte_req;
        set_unm = !mapped;
        if (cs_n) begin
          state_d = S_IDLE;
        end else begin
          tx_byte_d = (mapped && tx_en) ? tx_d : 8'h00;
          state_d   = S_RD_LOAD;
        end
      end
      S_RD_LOAD: begin
        set_ovr = tx_byte_req;
        state_d = cs_n ? S_IDLE : S_RD;
      end
      default: state_d = S_IDLE;
    endcase

    if (cnt_clr)
      byte_cnt_d = 8'd0;
    else if (cnt_inc && byte_cnt_q != 8'hFF)
      byte_cnt_d = byte_cnt_q + 8'd1;
    else
      byte_cnt_d = byte_cnt_q;

    // A new error in the clear cycle wins over err_clr.
    err_unm_d = set_unm || (err_unm_q && !err_clr);
    err_ovr_d = set_ovr || (err_ovr_q && !err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      reg_addr_q <= 7'd0;
      wr_pend_q  <= 1'b0;
      rx_d_q     <= 8'h00;
      tx_byte_q  <= 8'h00;
      byte_cnt_q <= 8'd0;
      err_unm_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_addr_q <= reg_addr_d;
      wr_pend_q  <= wr_pend_d;
      rx_d_q     <= rx_d_d;
      tx_byte_q  <= tx_byte_d;
      byte_cnt_q <= byte_cnt_d;
      err_unm_q  <= err_unm_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed bench for spi_reg_sequencer: bursts, streaming, errors, abort.
// Inputs change on the falling edge; outputs are checked there too.
module tb_spi_reg_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cs_n;
  logic [7:0] rx_byte;
  logic       rx_byte_dv;
  logic       tx_byte_req;
  logic [7:0] tx_byte;
  logic       tx_byte_load;
  logic [6:0] reg_addr;
  logic       addr_dv;
  logic       rw_out;
  logic       rxdv;
  logic [7:0] rx_d;
  logic [7:0] tx_d;
  logic       tx_en;
  logic       busy;
  logic [7:0] byte_cnt;
  logic       err_unmapped;
  logic       err_overrun;
  logic       err_clr;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  spi_reg_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cs_n         (cs_n),
    .rx_byte      (rx_byte),
    .rx_byte_dv   (rx_byte_dv),
    .tx_byte_req  (tx_byte_req),
    .tx_byte      (tx_byte),
    .tx_byte_load (tx_byte_load),
    .reg_addr     (reg_addr),
    .addr_dv      (addr_dv),
    .rw_out       (rw_out),
    .rxdv         (rxdv),
    .rx_d         (rx_d),
    .tx_d         (tx_d),
    .tx_en        (tx_en),
    .busy         (busy),
    .byte_cnt     (byte_cnt),
    .err_unmapped (err_unmapped),
    .err_overrun  (err_overrun),
    .err_clr      (err_clr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".busy"},  busy, 0);
    chk({tag, ".addr"},  reg_addr, 0);
    chk({tag, ".adv"},   addr_dv, 0);
    chk({tag, ".rxdv"},  rxdv, 0);
    chk({tag, ".rw"},    rw_out, 0);
    chk({tag, ".load"},  tx_byte_load, 0);
    chk({tag, ".rxd"},   rx_d, 0);
    chk({tag, ".txb"},   tx_byte, 0);
    chk({tag, ".cnt"},   byte_cnt, 0);
    chk({tag, ".eunm"},  err_unmapped, 0);
    chk({tag, ".eovr"},  err_overrun, 0);
  endtask

  task automatic cmd(input logic [7:0] c);
    cs_n = 1'b0;
    cyc();
    chk("cmd.busy", busy, 1);
    rx_byte = c;
    rx_byte_dv = 1'b1;
    cyc();
    rx_byte_dv = 1'b0;
    chk("cmd.addr", reg_addr, {25'd0, c[6:0]});
    chk("cmd.cnt", byte_cnt, 0);
  endtask

  logic [7:0] rdv [3];

  initial begin
    reset_n = 1'b0;
    cs_n = 1'b1;
    rx_byte = 8'h00;
    rx_byte_dv = 1'b0;
    tx_byte_req = 1'b0;
    tx_d = 8'h00;
    tx_en = 1'b0;
    err_clr = 1'b0;
    rdv[0] = 8'hC3;
    rdv[1] = 8'h5E;
    rdv[2] = 8'h01;
    cyc();
    cyc();
    chk_reset("rst");
    reset_n = 1'b1;
    cyc();
    chk("idle.busy", busy, 0);

    // write burst at 0x06
    cmd(8'h06);
    rx_byte = 8'hAA;
    rx_byte_dv = 1'b1;
    cyc();
    chk("wr0.adv", addr_dv, 1);
    chk("wr0.rxdv", rxdv, 1);
    chk("wr0.rw", rw_out, 0);
    chk("wr0.addr", reg_addr, 7'h06);
    chk("wr0.data", rx_d, 8'hAA);
    rx_byte = 8'h55;
    cyc();
    rx_byte_dv = 1'b0;
    chk("wr1.adv", addr_dv, 1);
    chk("wr1.addr", reg_addr, 7'h07);
    chk("wr1.data", rx_d, 8'h55);
    cyc();
    chk("wr.end.adv", addr_dv, 0);
    chk("wr.cnt", byte_cnt, 2);
    chk("wr.next", reg_addr, 7'h08);
    cs_n = 1'b1;
    cyc();
    chk("wr.idle", busy, 0);

    // FIFO read burst at 0x08
    cmd(8'h88);
    for (int i = 0; i < 3; i++) begin
      tx_byte_req = 1'b1;
      tx_d = rdv[i];
      tx_en = 1'b1;
      cyc();
      tx_byte_req = 1'b0;
      chk("fifo.adv", addr_dv, 1);
      chk("fifo.rw", rw_out, 1);
      chk("fifo.addr", reg_addr, 7'h08);
      chk("fifo.noload", tx_byte_load, 0);
      cyc();
      tx_d = 8'hEE;
      chk("fifo.load", tx_byte_load, 1);
      chk("fifo.data", tx_byte, rdv[i]);
      chk("fifo.adv0", addr_dv, 0);
      cyc();
      chk("fifo.load0", tx_byte_load, 0);
    end
    chk("fifo.cnt", byte_cnt, 3);
    chk("fifo.addr.end", reg_addr, 7'h08);
    tx_en = 1'b0;
    cs_n = 1'b1;
    cyc();

    // unmapped write at 0x7F, wrap to 0x00
    cmd(8'h7F);
    rx_byte = 8'h11;
    rx_byte_dv = 1'b1;
    cyc();
    chk("unm.adv", addr_dv, 0);
    chk("unm.rxdv", rxdv, 0);
    chk("unm.addr", reg_addr, 7'h7F);
    rx_byte = 8'h22;
    cyc();
    rx_byte_dv = 1'b0;
    chk("wrap.adv", addr_dv, 1);
    chk("wrap.addr", reg_addr, 7'h00);
    chk("wrap.data", rx_d, 8'h22);
    chk("unm.err", err_unmapped, 1);
    cyc();
    chk("wrap.cnt", byte_cnt, 2);
    cs_n = 1'b1;
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("unm.clr", err_unmapped, 0);

    // overrun: two back-to-back requests
    cmd(8'h81);
    tx_byte_req = 1'b1;
    tx_d = 8'h5A;
    tx_en = 1'b0;
    cyc();
    chk("ovr.adv", addr_dv, 1);
    cyc();
    tx_byte_req = 1'b0;
    chk("ovr.load", tx_byte_load, 1);
    chk("ovr.txen0", tx_byte, 8'h00);
    chk("ovr.err", err_overrun, 1);
    cyc();
    chk("ovr.adv0", addr_dv, 0);
    chk("ovr.addr", reg_addr, 7'h02);
    cyc();
    chk("ovr.one", addr_dv, 0);
    chk("ovr.cnt", byte_cnt, 1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("ovr.clr", err_overrun, 0);
    cs_n = 1'b1;
    cyc();

    // abort during RD_FETCH
    cmd(8'h82);
    tx_byte_req = 1'b1;
    tx_d = 8'h33;
    tx_en = 1'b1;
    cyc();
    tx_byte_req = 1'b0;
    cs_n = 1'b1;
    #1;
    chk("abt.adv", addr_dv, 1);
    cyc();
    chk("abt.load", tx_byte_load, 0);
    chk("abt.busy", busy, 0);
    chk("abt.adv0", addr_dv, 0);
    cyc();
    chk("abt.load1", tx_byte_load, 0);
    tx_en = 1'b0;

    // async reset mid write burst
    cmd(8'h03);
    rx_byte = 8'h44;
    rx_byte_dv = 1'b1;
    cyc();
    chk("ar.adv", addr_dv, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("ar");
    cyc();
    chk("ar.hold", addr_dv, 0);
    cyc();
    chk("ar.hold2", rxdv, 0);
    rx_byte_dv = 1'b0;
    cs_n = 1'b1;
    reset_n = 1'b1;
    cyc();
    chk("ar.idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
